// File: rtl/config_reg_block_pkg.sv
// config_reg_block_pkg
// Shared definitions for the configuration register block: register
// addresses, power-on configuration values, command bit positions and the
// bus-handshake FSM state encoding.
package config_reg_block_pkg;

    // Register addresses; anything at or above NUM_REGS is unmapped
    localparam logic [2:0]  REG_CTRL0       = 3'd0;
    localparam logic [2:0]  REG_CTRL1       = 3'd1;
    localparam logic [2:0]  REG_THR_CORRUPT = 3'd2;
    localparam logic [2:0]  REG_THR_TTC     = 3'd3;
    localparam logic [2:0]  REG_THR_DDR3    = 3'd4;
    localparam logic [2:0]  REG_CMD         = 3'd5;
    localparam int unsigned NUM_REGS        = 6;

    // Configuration values after reset
    localparam logic [4:0]  RST_CHAN_EN        = 5'h1F;
    localparam logic [2:0]  RST_FILL_TYPE      = 3'd1;
    localparam logic        RST_ENDIANNESS     = 1'b0;
    localparam logic [3:0]  RST_TRIG_DELAY     = 4'd0;
    localparam logic [7:0]  RST_TRIG_SETTINGS  = 8'd0;
    localparam logic [4:0]  RST_READOUT_PAUSE  = 5'd0;
    localparam logic [31:0] RST_THRESHOLD      = 32'd1;

    // Bit positions inside the command register
    localparam int CMD_RST_ERR_COUNTS = 0;
    localparam int CMD_SOFT_RST       = 1;
    localparam int CMD_CLR_TRIG_NUM   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/config_reg_block.sv
// config_reg_block
// IPbus write/read slave holding all software-settable configuration and
// generating one-cycle command strobes.
//
// Optional feature macro: CFG_READBACK_EN
//   defined   -> reads of 0x0-0x4 return register contents (0x5 reads 0) with ack
//   undefined -> every read is answered with err and rdata 0
//
// Ports:
//   clk, reset (synchronous, active-high)
//   ipb_strobe/ipb_write/ipb_addr/ipb_wdata : request from the transaction decoder
//   ipb_rdata/ipb_ack/ipb_err               : one-cycle response
//   chan_en .. thres_ddr3_overflow          : configuration outputs
//   rst_err_counts, soft_rst, clr_trig_num  : one-cycle command pulses
//   cfg_changed                             : pulse after an accepted write to 0x0-0x4
module config_reg_block
    import config_reg_block_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ipb_strobe,
    input  logic              ipb_write,
    input  logic [ADDR_W-1:0] ipb_addr,
    input  logic [31:0]       ipb_wdata,
    output logic [31:0]       ipb_rdata,
    output logic              ipb_ack,
    output logic              ipb_err,
    output logic [4:0]        chan_en,
    output logic [2:0]        fill_type,
    output logic              endianness_sel,
    output logic [3:0]        trig_delay,
    output logic [7:0]        trig_settings,
    output logic [4:0]        acq_readout_pause,
    output logic [31:0]       thres_data_corrupt,
    output logic [31:0]       thres_unknown_ttc,
    output logic [31:0]       thres_ddr3_overflow,
    output logic              rst_err_counts,
    output logic              soft_rst,
    output logic              clr_trig_num,
    output logic              cfg_changed
);

    state_t      state;
    logic        req_write;
    logic        req_mapped;
    logic [2:0]  req_sel;
    logic [31:0] req_wdata;

`ifdef CFG_READBACK_EN
    logic [31:0] readback;

    // Readback mux for the captured address; reserved bits read as 0
    always_comb begin
        readback = 32'd0;
        case (req_sel)
            REG_CTRL0:       readback = {19'd0, trig_delay, endianness_sel, fill_type, chan_en};
            REG_CTRL1:       readback = {19'd0, acq_readout_pause, trig_settings};
            REG_THR_CORRUPT: readback = thres_data_corrupt;
            REG_THR_TTC:     readback = thres_unknown_ttc;
            REG_THR_DDR3:    readback = thres_ddr3_overflow;
            default:         readback = 32'd0;
        endcase
    end
`endif

    // Handshake FSM plus register file. The request is captured on acceptance
    // and only acted upon at the end of RESP, so a reset arriving during RESP
    // discards the transaction without any response or register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= ST_IDLE;
            req_write           <= 1'b0;
            req_mapped          <= 1'b0;
            req_sel             <= 3'd0;
            req_wdata           <= 32'd0;
            ipb_ack             <= 1'b0;
            ipb_err             <= 1'b0;
            ipb_rdata           <= 32'd0;
            rst_err_counts      <= 1'b0;
            soft_rst            <= 1'b0;
            clr_trig_num        <= 1'b0;
            cfg_changed         <= 1'b0;
            chan_en             <= RST_CHAN_EN;
            fill_type           <= RST_FILL_TYPE;
            endianness_sel      <= RST_ENDIANNESS;
            trig_delay          <= RST_TRIG_DELAY;
            trig_settings       <= RST_TRIG_SETTINGS;
            acq_readout_pause   <= RST_READOUT_PAUSE;
            thres_data_corrupt  <= RST_THRESHOLD;
            thres_unknown_ttc   <= RST_THRESHOLD;
            thres_ddr3_overflow <= RST_THRESHOLD;
        end else begin
            // Response and pulses default low so they last exactly one cycle
            ipb_ack        <= 1'b0;
            ipb_err        <= 1'b0;
            ipb_rdata      <= 32'd0;
            rst_err_counts <= 1'b0;
            soft_rst       <= 1'b0;
            clr_trig_num   <= 1'b0;
            cfg_changed    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (ipb_strobe) begin
                        req_write  <= ipb_write;
                        req_mapped <= (32'(ipb_addr) < NUM_REGS);
                        req_sel    <= ipb_addr[2:0];
                        req_wdata  <= ipb_wdata;
                        state      <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    state <= ST_WAIT;
                    if (!req_mapped) begin
                        ipb_err <= 1'b1;
                    end else if (req_write) begin
                        ipb_ack <= 1'b1;
                        case (req_sel)
                            REG_CTRL0: begin
                                chan_en        <= req_wdata[4:0];
                                fill_type      <= req_wdata[7:5];
                                endianness_sel <= req_wdata[8];
                                trig_delay     <= req_wdata[12:9];
                            end
                            REG_CTRL1: begin
                                trig_settings     <= req_wdata[7:0];
                                acq_readout_pause <= req_wdata[12:8];
                            end
                            REG_THR_CORRUPT: thres_data_corrupt  <= req_wdata;
                            REG_THR_TTC:     thres_unknown_ttc   <= req_wdata;
                            REG_THR_DDR3:    thres_ddr3_overflow <= req_wdata;
                            default: begin
                                rst_err_counts <= req_wdata[CMD_RST_ERR_COUNTS];
                                soft_rst       <= req_wdata[CMD_SOFT_RST];
                                clr_trig_num   <= req_wdata[CMD_CLR_TRIG_NUM];
                            end
                        endcase
                        // The command register is not configuration
                        cfg_changed <= (req_sel != REG_CMD);
                    end else begin
`ifdef CFG_READBACK_EN
                        ipb_ack   <= 1'b1;
                        ipb_rdata <= readback;
`else
                        ipb_err   <= 1'b1;
`endif
                    end
                end

                ST_WAIT: begin
                    if (!ipb_strobe) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_reg_block.sv
// tb_config_reg_block
// Self-checking bench for config_reg_block. A register-map model (an array of
// five masked words plus the command semantics) predicts every response and
// every configuration output; directed steps cover the documented scenarios
// and a randomized run follows.
module tb_config_reg_block;

`ifdef CFG_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ipb_strobe = 1'b0;
    logic        ipb_write = 1'b0;
    logic [3:0]  ipb_addr = 4'd0;
    logic [31:0] ipb_wdata = 32'd0;
    logic [31:0] ipb_rdata;
    logic        ipb_ack, ipb_err;
    logic [4:0]  chan_en;
    logic [2:0]  fill_type;
    logic        endianness_sel;
    logic [3:0]  trig_delay;
    logic [7:0]  trig_settings;
    logic [4:0]  acq_readout_pause;
    logic [31:0] thres_data_corrupt, thres_unknown_ttc, thres_ddr3_overflow;
    logic        rst_err_counts, soft_rst, clr_trig_num, cfg_changed;

    int checks = 0;
    int errors = 0;

    // Model: the five readable registers as plain masked words
    logic [31:0] model_reg [5];
    logic [31:0] reg_mask  [5];

    config_reg_block #(.ADDR_W(4)) dut (
        .clk(clk), .reset(reset),
        .ipb_strobe(ipb_strobe), .ipb_write(ipb_write),
        .ipb_addr(ipb_addr), .ipb_wdata(ipb_wdata),
        .ipb_rdata(ipb_rdata), .ipb_ack(ipb_ack), .ipb_err(ipb_err),
        .chan_en(chan_en), .fill_type(fill_type), .endianness_sel(endianness_sel),
        .trig_delay(trig_delay), .trig_settings(trig_settings),
        .acq_readout_pause(acq_readout_pause),
        .thres_data_corrupt(thres_data_corrupt), .thres_unknown_ttc(thres_unknown_ttc),
        .thres_ddr3_overflow(thres_ddr3_overflow),
        .rst_err_counts(rst_err_counts), .soft_rst(soft_rst),
        .clr_trig_num(clr_trig_num), .cfg_changed(cfg_changed)
    );

    always #5 clk = ~clk;

    // Restore the power-on register map in the model
    task automatic modelReset();
        model_reg[0] = 32'h0000_003F;
        model_reg[1] = 32'h0000_0000;
        model_reg[2] = 32'd1;
        model_reg[3] = 32'd1;
        model_reg[4] = 32'd1;
        reg_mask[0]  = 32'h0000_1FFF;
        reg_mask[1]  = 32'h0000_1FFF;
        reg_mask[2]  = 32'hFFFF_FFFF;
        reg_mask[3]  = 32'hFFFF_FFFF;
        reg_mask[4]  = 32'hFFFF_FFFF;
    endtask

    // One comparison: counts it, and on mismatch counts and reports the failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // All configuration outputs against the model register words
    task automatic checkConfig(input string tag);
        logic [31:0] r0, r1;
        r0 = model_reg[0];
        r1 = model_reg[1];
        checkOutput({tag, ".chan_en"},    32'(chan_en),           32'(r0[4:0]));
        checkOutput({tag, ".fill_type"},  32'(fill_type),         32'(r0[7:5]));
        checkOutput({tag, ".endian"},     32'(endianness_sel),    32'(r0[8]));
        checkOutput({tag, ".trig_delay"}, 32'(trig_delay),        32'(r0[12:9]));
        checkOutput({tag, ".trig_set"},   32'(trig_settings),     32'(r1[7:0]));
        checkOutput({tag, ".pause"},      32'(acq_readout_pause), 32'(r1[12:8]));
        checkOutput({tag, ".thr_corr"},   thres_data_corrupt,     model_reg[2]);
        checkOutput({tag, ".thr_ttc"},    thres_unknown_ttc,      model_reg[3]);
        checkOutput({tag, ".thr_ddr3"},   thres_ddr3_overflow,    model_reg[4]);
    endtask

    // Response bus and pulses must all be quiet outside the response cycle
    task automatic checkQuiet(input string tag);
        checkOutput({tag, ".idle_resp"},
                    {24'd0, ipb_ack, ipb_err, rst_err_counts, soft_rst, clr_trig_num,
                     cfg_changed, 2'd0}, 32'd0);
        checkOutput({tag, ".idle_rdata"}, ipb_rdata, 32'd0);
    endtask

    // Wait (bounded) for a response; returns cycles from the accepting edge
    task automatic waitResponse(output int latency);
        latency = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (ipb_ack || ipb_err) begin
                latency = i;
                break;
            end
        end
    endtask

    // Full transaction: predict, drive, check response and outputs, then hold
    // strobe for 'hold' extra cycles and release it
    task automatic applyStimulus(input string tag, input bit wr, input logic [3:0] addr,
                                 input logic [31:0] data, input int hold);
        bit          exp_ack, exp_err, exp_cfg;
        logic [31:0] exp_rdata;
        logic [2:0]  exp_cmd;
        int          latency;
        int          extra;

        exp_ack = 0; exp_err = 0; exp_cfg = 0; exp_rdata = 32'd0; exp_cmd = 3'd0;
        if (addr >= 4'd6) begin
            exp_err = 1;
        end else if (wr) begin
            exp_ack = 1;
            if (addr == 4'd5) exp_cmd = data[2:0];
            else exp_cfg = 1;
        end else if (READBACK) begin
            exp_ack = 1;
            exp_rdata = (addr < 4'd5) ? model_reg[addr] : 32'd0;
        end else begin
            exp_err = 1;
        end

        @(negedge clk);
        ipb_strobe = 1'b1;
        ipb_write  = wr;
        ipb_addr   = addr;
        ipb_wdata  = data;

        waitResponse(latency);
        checkOutput({tag, ".latency"}, 32'(latency), 32'd2);
        checkOutput({tag, ".ack"},     32'(ipb_ack), 32'(exp_ack));
        checkOutput({tag, ".err"},     32'(ipb_err), 32'(exp_err));
        checkOutput({tag, ".rdata"},   ipb_rdata,    exp_rdata);
        checkOutput({tag, ".cfg_chg"}, 32'(cfg_changed), 32'(exp_cfg));
        checkOutput({tag, ".cmd"},
                    32'({clr_trig_num, soft_rst, rst_err_counts}), 32'(exp_cmd));

        if (wr && addr < 4'd5) model_reg[addr] = data & reg_mask[addr];
        checkConfig(tag);

        extra = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (ipb_ack || ipb_err) extra++;
        end
        ipb_strobe = 1'b0;
        @(posedge clk);
        #1;
        if (ipb_ack || ipb_err) extra++;
        checkOutput({tag, ".extra_resp"}, 32'(extra), 32'd0);
        checkQuiet(tag);
    endtask

    initial begin
        int latency;
        modelReset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkConfig("reset");
        checkQuiet("reset");
        checkOutput("reset.chan_en_const", 32'(chan_en), 32'h1F);

        // Readback of reset values
        applyStimulus("rd0", 1'b0, 4'h0, 32'd0, 0);
        applyStimulus("rd2", 1'b0, 4'h2, 32'd0, 0);

        // Control word write
        applyStimulus("wr0", 1'b1, 4'h0, 32'h0000_1A35, 0);
        checkOutput("wr0.chan_const",  32'(chan_en),    32'h15);
        checkOutput("wr0.delay_const", 32'(trig_delay), 32'hD);

        // Command writes
        applyStimulus("cmd5", 1'b1, 4'h5, 32'h5, 0);
        applyStimulus("cmd0", 1'b1, 4'h5, 32'h0, 0);
        applyStimulus("rd5",  1'b0, 4'h5, 32'd0, 0);

        // Unmapped accesses with a long strobe
        applyStimulus("rd9", 1'b0, 4'h9, 32'd0, 10);
        applyStimulus("wr9", 1'b1, 4'h9, 32'hFFFF_FFFF, 10);

        // Threshold read then write, same-value write still flags a change
        applyStimulus("rd3",  1'b0, 4'h3, 32'd0, 0);
        applyStimulus("wr3",  1'b1, 4'h3, 32'd500, 0);
        checkOutput("wr3.const", thres_unknown_ttc, 32'd500);
        applyStimulus("wr3b", 1'b1, 4'h3, 32'd500, 2);

        // Reset during RESP of a 0x2 write, strobe held across the release
        @(negedge clk);
        ipb_strobe = 1'b1;
        ipb_write  = 1'b1;
        ipb_addr   = 4'h2;
        ipb_wdata  = 32'hCAFE_0002;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        modelReset();
        checkOutput("rstresp.ack", 32'({ipb_ack, ipb_err}), 32'd0);
        checkConfig("rstresp");
        checkOutput("rstresp.thr_const", thres_data_corrupt, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        waitResponse(latency);
        checkOutput("rstresp.new_ack", 32'(ipb_ack), 32'd1);
        model_reg[2] = 32'hCAFE_0002;
        checkConfig("rstresp.new");
        ipb_strobe = 1'b0;
        @(posedge clk);
        #1;
        checkQuiet("rstresp.after");

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            bit          wr;
            logic [3:0]  addr;
            logic [31:0] data;
            wr   = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 8));
            data = $urandom;
            applyStimulus($sformatf("rnd%0d", n), wr, addr, data, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
